// File: rtl/forwarding_register_file_pkg.sv
// Shared processor package for the forwarding register file.
// Holds the default parameter values and the architectural zero-register index.
package forwarding_register_file_pkg;

  localparam int unsigned DATA_W_DEF = 32;  // register width
  localparam int unsigned ADDR_W_DEF = 5;   // index width, depth = 2**ADDR_W
  localparam int unsigned NUM_RD_DEF = 2;   // read ports (1..4)
  localparam int unsigned DBG_W_DEF  = 8;   // debug readout width (<= DATA_W)

  // Index that is hardwired to zero and never tracked as busy.
  localparam int unsigned ZERO_IDX = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one pending bit per register index.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   set_vec    : one-hot(ish) set requests (issue of a producer)
//   clr_vec    : clear requests (writeback)
//   busy       : registered busy vector
// A simultaneous set and clear of the same bit leaves it set.
module reg_scoreboard #(
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] set_vec,
  input  logic [DEPTH-1:0] clr_vec,
  output logic [DEPTH-1:0] busy
);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: rtl/forwarding_register_file.sv
// Register file with write-through bypass, per-register scoreboard and a
// registered debug readout.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   RegWrite/Write_register/Write_data : write port
//   Issue_valid/Issue_register      : marks a destination as pending
//   Read_register/Read_data         : NUM_RD packed combinational read ports
//   Read_busy                       : per-port "value not yet valid"
//   Debug_sel/Debug_data            : registered low DBG_W bits of a register
//   Busy_any                        : OR of all scoreboard bits
module forwarding_register_file
  import forwarding_register_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF,
  parameter int unsigned DBG_W  = DBG_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        Write_register,
  input  logic [DATA_W-1:0]        Write_data,
  input  logic                     Issue_valid,
  input  logic [ADDR_W-1:0]        Issue_register,
  input  logic [NUM_RD*ADDR_W-1:0] Read_register,
  output logic [NUM_RD*DATA_W-1:0] Read_data,
  output logic [NUM_RD-1:0]        Read_busy,
  input  logic [ADDR_W-1:0]        Debug_sel,
  output logic [DBG_W-1:0]         Debug_data,
  output logic                     Busy_any
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  set_vec;
  logic [DEPTH-1:0]  clr_vec;
  logic              wr_en;
  logic [DBG_W-1:0]  dbg_next;

  // Writes to the zero index are dropped everywhere, including the bypass.
  assign wr_en = RegWrite && (Write_register != ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[Write_register] <= Write_data;
    end
  end

  // Issue sets, writeback clears; the scoreboard lets set win on a collision.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (Issue_valid && (Issue_register != ZERO)) begin
      set_vec[Issue_register] = 1'b1;
    end
    if (wr_en) begin
      clr_vec[Write_register] = 1'b1;
    end
  end

  reg_scoreboard #(
    .DEPTH(DEPTH)
  ) u_scoreboard (
    .clk    (clk),
    .reset  (reset),
    .set_vec(set_vec),
    .clr_vec(clr_vec),
    .busy   (busy)
  );

  assign Busy_any = |busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic              hit;
    logic [DATA_W-1:0] val;

    assign idx = Read_register[k*ADDR_W +: ADDR_W];
    assign hit = wr_en && (Write_register == idx);

    always_comb begin
      if (idx == ZERO) begin
        val = '0;
      end else if (hit) begin
        val = Write_data;
      end else begin
        val = regs[idx];
      end
    end

    assign Read_data[k*DATA_W +: DATA_W] = val;
    // A writeback in this very cycle delivers the value, so the reader need not stall.
    assign Read_busy[k] = busy[idx] && !hit;
  end

  always_comb begin
    if (Debug_sel == ZERO) begin
      dbg_next = '0;
    end else if (wr_en && (Write_register == Debug_sel)) begin
      dbg_next = Write_data[DBG_W-1:0];
    end else begin
      dbg_next = regs[Debug_sel][DBG_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Debug_data <= '0;
    end else begin
      Debug_data <= dbg_next;
    end
  end

endmodule

// File: doc/forwarding_register_file.md
FORWARDING_REGISTER_FILE -- requirements
Module: forwarding_register_file

Interface
REQ-001 DATA_W, 32, register width in bits.
REQ-002 ADDR_W, 5, register index width; depth = 2**ADDR_W entries.
REQ-003 NUM_RD, 2, number of independent read ports (1..4).
REQ-004 DBG_W, 8, width of debug readout (DBG_W <= DATA_W).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 RegWrite  input  1  write-port enable.
REQ-008 Write_register  input  ADDR_W  write index.
REQ-009 Write_data  input  DATA_W  write data.
REQ-010 Issue_valid  input  1  marks Issue_register as pending (scoreboard set).
REQ-011 Issue_register  input  ADDR_W  destination index of an in-flight producer.
REQ-012 Read_register  input  NUM_RD*ADDR_W  read indices; port k at bits [k*ADDR_W +: ADDR_W].
REQ-013 Read_data  output  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W].
REQ-014 Read_busy  output  NUM_RD  port k value is not yet valid (consumer must stall).
REQ-015 Debug_sel  input  ADDR_W  debug register index.
REQ-016 Debug_data  output  DBG_W  registered low DBG_W bits of selected register.
REQ-017 Busy_any  output  1  OR of all scoreboard bits.

Function
REQ-018 Index 0 SHALL read as zero, never be busy; writes and issues to index 0 SHALL be ignored.
REQ-019 Reads SHALL be combinational, zero-cycle latency, per port independent.
REQ-020 When RegWrite=1, Write_register=Read_register[k]!=0, Read_data[k] SHALL equal Write_data in the same cycle (write-through bypass).
REQ-021 Otherwise Read_data[k] SHALL equal stored value of the indexed register.
REQ-022 Write SHALL update storage on the rising edge when RegWrite=1 and Write_register!=0.
REQ-023 Scoreboard: one busy bit per index; Issue_valid=1 sets busy[Issue_register] at next edge.
REQ-024 RegWrite=1 SHALL clear busy[Write_register] at next edge.
REQ-025 Issue and write to same index in same cycle: busy SHALL end set (issue wins); storage still takes Write_data.
REQ-026 Read_busy[k] SHALL be busy[idx] AND NOT (RegWrite and Write_register=idx); i.e. a same-cycle writeback un-stalls the reader.
REQ-027 Issue in cycle n SHALL NOT affect Read_busy in cycle n; visible from cycle n+1.
REQ-028 Debug_data SHALL be registered: value at edge n+1 = low DBG_W bits of register Debug_sel sampled at edge n, post-bypass (includes a same-cycle write).
REQ-029 Busy_any SHALL reflect the registered scoreboard only (no bypass term).

Reset
REQ-030 reset=1 at a rising edge SHALL clear all registers, all busy bits and Debug_data to 0.
REQ-031 reset SHALL take priority over a simultaneous write or issue; both are discarded.
REQ-032 During reset cycles Read_data SHALL still follow REQ-019..021 combinationally; outputs settle to 0 after the first reset edge.

Structure
REQ-033 Default parameter values and the zero-index constant SHALL live in the shared processor package.
REQ-034 Scoreboard SHALL be a separate sub-module reg_scoreboard (set/clear vectors in, busy vector out).
REQ-035 Storage SHALL be a flat array of 2**ADDR_W entries; entry 0 may be omitted.

Verification
REQ-036 Reset then write 0xDEADBEEF to r4, read r4 next cycle on port 0 -> 0xDEADBEEF; Debug_sel=4 -> Debug_data=0xEF one cycle later.
REQ-037 Same-cycle write 0x12345678 to r7 with port 1 reading r7 -> Read_data port 1 = 0x12345678 that cycle.
REQ-038 Write 0xFFFFFFFF to r0, issue r0 -> r0 reads 0, Read_busy=0, Busy_any=0.
REQ-039 Issue r29 cycle 1; read r29 cycle 2 -> Read_busy=1; write 0x55 to r29 cycle 3 -> Read_busy=0, data 0x55 same cycle; cycle 4 Busy_any=0.
REQ-040 Issue r31 and write 0xAA to r31 same cycle -> next cycle r31 busy=1, stored 0xAA.
REQ-041 Fill r1..r31, issue r2, assert reset together with write to r3 -> next cycle all reads 0, Busy_any=0, Debug_data=0.
